fp_add_sequencer: RTL and testbench

- Front-end initiator that drives the FP adder's Control block; supplies every handshake input Control consumes.
- Accepts two packed single-precision-style operands over a valid/ready handshake and compares exponents to produce Go/ExpSet/ExpDiff.
- Captures the datapath's unnormalized sum and runs leading-one detection to produce FFOValid/FFOIndex.
- Holds all issued values stable until Control signals completion.

---
 rtl/fp_add_pkg.sv | 17 +
 rtl/leading_one_finder.sv | 25 ++
 rtl/fp_add_sequencer.sv | 139 +++++++++++++
 tb/tb_fp_add_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_add_pkg.sv
// Shared constants and state encoding for the FP adder front-end sequencer.
package fp_add_pkg;

  localparam int EXPBITS      = 8;
  localparam int MANTISSABITS = 23;
  localparam int NBITS        = $clog2(MANTISSABITS);

  // Sequencer states; the encoding is visible on the debug state output.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_SUM  = 3'd2,
    S_FIND      = 3'd3,
    S_WAIT_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/leading_one_finder.sv
// Combinational leading-one detector over the unnormalized sum
// {carry, hidden, mantissa}. Reports whether any bit is set and the
// position of the most significant set bit (0 when the sum is zero).
module leading_one_finder #(
  parameter int MANTISSABITS = 23,
  localparam int NBITS       = $clog2(MANTISSABITS)
) (
  input  logic [MANTISSABITS+1:0] sum_i,
  output logic                    valid_o,
  output logic [NBITS-1:0]        index_o
);

  // Ascending scan: the highest set bit is the last one to write the index.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    for (int i = 0; i < MANTISSABITS + 2; i++) begin
      if (sum_i[i]) begin
        valid_o = 1'b1;
        index_o = NBITS'(i);
      end
    end
  end

endmodule

// File: rtl/fp_add_sequencer.sv
// Front-end initiator for the FP adder Control block.
//
// Handshake: an operand pair transfers on a posedge where InValid and
// InReady are both high. InReady is high only in IDLE; outside IDLE the
// source must hold InValid and its operands until accepted. SumValid is
// only observed in WAIT_SUM and Done only in WAIT_DONE; elsewhere they
// are ignored.
//
// Issued values (ExpSet/ExpDiff, then FFOValid/FFOIndex) are held
// stable until Done, and clear on the edge that returns to IDLE.
module fp_add_sequencer #(
  parameter int EXPBITS      = fp_add_pkg::EXPBITS,
  parameter int MANTISSABITS = fp_add_pkg::MANTISSABITS,
  localparam int NBITS       = $clog2(MANTISSABITS),
  localparam int OPBITS      = EXPBITS + MANTISSABITS + 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [OPBITS-1:0]       OpA,
  input  logic [OPBITS-1:0]       OpB,
  output logic                    Go,
  output logic                    ExpSet,
  output logic [EXPBITS-1:0]      ExpDiff,
  input  logic                    SumValid,
  input  logic [MANTISSABITS+1:0] Sum,
  output logic                    FFOValid,
  output logic [NBITS-1:0]        FFOIndex,
  input  logic                    Done,
  output logic                    Busy,
  output logic [2:0]              DbgState
);

  import fp_add_pkg::*;

  seq_state_t               state_q;
  logic                     go_q;
  logic                     exp_set_q;
  logic [EXPBITS-1:0]       exp_diff_q;
  logic [MANTISSABITS+1:0]  sum_q;
  logic                     ffo_valid_q;
  logic [NBITS-1:0]         ffo_index_q;

  logic [EXPBITS-1:0]       exp_a;
  logic [EXPBITS-1:0]       exp_b;
  logic                     exp_set_d;
  logic [EXPBITS-1:0]       exp_diff_d;
  logic                     lof_valid;
  logic [NBITS-1:0]         lof_index;

  // Only the exponent fields matter to this block; signs and mantissas
  // travel down the datapath by other means.
  logic                     unused_op_bits;
  assign unused_op_bits = ^{OpA[OPBITS-1], OpA[MANTISSABITS-1:0],
                            OpB[OPBITS-1], OpB[MANTISSABITS-1:0]};

  // Exponent compare is done on the operands at the accept edge so that
  // ExpSet/ExpDiff are already valid in the ISSUE cycle alongside Go.
  always_comb begin
    exp_a      = OpA[OPBITS-2 -: EXPBITS];
    exp_b      = OpB[OPBITS-2 -: EXPBITS];
    exp_set_d  = (exp_a >= exp_b);
    exp_diff_d = exp_set_d ? (exp_a - exp_b) : (exp_b - exp_a);
  end

  leading_one_finder #(
    .MANTISSABITS(MANTISSABITS)
  ) u_lof (
    .sum_i   (sum_q),
    .valid_o (lof_valid),
    .index_o (lof_index)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      go_q        <= 1'b0;
      exp_set_q   <= 1'b0;
      exp_diff_q  <= '0;
      sum_q       <= '0;
      ffo_valid_q <= 1'b0;
      ffo_index_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (InValid) begin
            go_q       <= 1'b1;
            exp_set_q  <= exp_set_d;
            exp_diff_q <= exp_diff_d;
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          go_q    <= 1'b0;
          state_q <= S_WAIT_SUM;
        end
        S_WAIT_SUM: begin
          if (SumValid) begin
            sum_q   <= Sum;
            state_q <= S_FIND;
          end
        end
        S_FIND: begin
          ffo_valid_q <= lof_valid;
          ffo_index_q <= lof_index;
          state_q     <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (Done) begin
            ffo_valid_q <= 1'b0;
            ffo_index_q <= '0;
            exp_set_q   <= 1'b0;
            exp_diff_q  <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          go_q    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Status derived from the registered state only.
  always_comb begin
    InReady  = (state_q == S_IDLE);
    Busy     = (state_q != S_IDLE);
    DbgState = state_q;
    Go       = go_q;
    ExpSet   = exp_set_q;
    ExpDiff  = exp_diff_q;
    FFOValid = ffo_valid_q;
    FFOIndex = ffo_index_q;
  end

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer. Inputs change and outputs are
// checked on the falling edge, half a cycle away from the active edge.
module tb_fp_add_sequencer;

  localparam int EB = 8;
  localparam int MB = 23;
  localparam int NB = 5;
  localparam int OB = EB + MB + 1;

  logic          Clock;
  logic          Reset;
  logic          InValid;
  logic          InReady;
  logic [OB-1:0] OpA;
  logic [OB-1:0] OpB;
  logic          Go;
  logic          ExpSet;
  logic [EB-1:0] ExpDiff;
  logic          SumValid;
  logic [MB+1:0] Sum;
  logic          FFOValid;
  logic [NB-1:0] FFOIndex;
  logic          Done;
  logic          Busy;
  logic [2:0]    DbgState;

  int total = 0;
  int bad   = 0;

  fp_add_sequencer dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .OpA      (OpA),
    .OpB      (OpB),
    .Go       (Go),
    .ExpSet   (ExpSet),
    .ExpDiff  (ExpDiff),
    .SumValid (SumValid),
    .Sum      (Sum),
    .FFOValid (FFOValid),
    .FFOIndex (FFOIndex),
    .Done     (Done),
    .Busy     (Busy),
    .DbgState (DbgState)
  );

  // Clock
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic step();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [OB-1:0] mk_op(input logic [EB-1:0] e, input logic [MB-1:0] m);
    return {1'b0, e, m};
  endfunction

  // Full operation with no stalls; checks every state's visible outputs.
  task automatic run_op(input string nm, input logic [EB-1:0] ea, input logic [EB-1:0] eb,
                        input logic [MB+1:0] s, input logic xset, input logic [EB-1:0] xdiff,
                        input logic xv, input logic [NB-1:0] xidx);
    InValid = 1'b1;
    OpA = mk_op(ea, 23'h12345);
    OpB = mk_op(eb, 23'h6789a);
    step();
    InValid = 1'b0;
    check({nm, ".issue_go"},    32'(Go), 32'd1);
    check({nm, ".issue_set"},   32'(ExpSet), 32'(xset));
    check({nm, ".issue_diff"},  32'(ExpDiff), 32'(xdiff));
    check({nm, ".issue_ready"}, 32'(InReady), 32'd0);
    check({nm, ".issue_state"}, 32'(DbgState), 32'd1);
    step();
    check({nm, ".ws_go"},   32'(Go), 32'd0);
    check({nm, ".ws_diff"}, 32'(ExpDiff), 32'(xdiff));
    SumValid = 1'b1;
    Sum = s;
    step();
    SumValid = 1'b0;
    Sum = '0;
    check({nm, ".find_state"}, 32'(DbgState), 32'd3);
    check({nm, ".find_ffov"},  32'(FFOValid), 32'd0);
    step();
    check({nm, ".wd_ffov"}, 32'(FFOValid), 32'(xv));
    check({nm, ".wd_idx"},  32'(FFOIndex), 32'(xidx));
    step();
    check({nm, ".hold_idx"},  32'(FFOIndex), 32'(xidx));
    check({nm, ".hold_set"},  32'(ExpSet), 32'(xset));
    check({nm, ".hold_busy"}, 32'(Busy), 32'd1);
    Done = 1'b1;
    step();
    Done = 1'b0;
    check({nm, ".clr_ffov"},  32'(FFOValid), 32'd0);
    check({nm, ".clr_idx"},   32'(FFOIndex), 32'd0);
    check({nm, ".clr_set"},   32'(ExpSet), 32'd0);
    check({nm, ".clr_diff"},  32'(ExpDiff), 32'd0);
    check({nm, ".clr_ready"}, 32'(InReady), 32'd1);
    check({nm, ".clr_busy"},  32'(Busy), 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    InValid = 1'b0;
    OpA = '0;
    OpB = '0;
    SumValid = 1'b0;
    Sum = '0;
    Done = 1'b0;
    @(negedge Clock);
    step();
    Reset = 1'b0;

    // Reset state
    check("rst.ready", 32'(InReady), 32'd1);
    check("rst.busy",  32'(Busy), 32'd0);
    check("rst.go",    32'(Go), 32'd0);
    check("rst.set",   32'(ExpSet), 32'd0);
    check("rst.diff",  32'(ExpDiff), 32'd0);
    check("rst.ffov",  32'(FFOValid), 32'd0);
    check("rst.idx",   32'(FFOIndex), 32'd0);
    check("rst.state", 32'(DbgState), 32'd0);

    // Idle with no InValid: stays idle, Done ignored
    Done = 1'b1;
    step();
    Done = 1'b0;
    check("idle.stay", 32'(DbgState), 32'd0);

    // Carry-out sum, ExpA > ExpB
    run_op("t1", 8'h55, 8'h00, 25'h1000000, 1'b1, 8'h55, 1'b1, 5'd24);
    // Equal exponents, bits 22..0 set
    run_op("t2", 8'h00, 8'h00, 25'h07FFFFF, 1'b1, 8'h00, 1'b1, 5'd22);
    // ExpA < ExpB, already normalized
    run_op("t3", 8'h00, 8'h55, 25'h0FFFFFF, 1'b0, 8'h55, 1'b1, 5'd23);
    // Zero sum, extreme exponents
    run_op("t4", 8'hFF, 8'h01, 25'h0000000, 1'b1, 8'hFE, 1'b0, 5'd0);
    // Only bit 0 set
    run_op("t5", 8'h01, 8'hFF, 25'h0000001, 1'b0, 8'hFE, 1'b1, 5'd0);

    // Reset in WAIT_SUM abandons the operation
    InValid = 1'b1;
    OpA = mk_op(8'h80, 23'h0);
    OpB = mk_op(8'h7F, 23'h0);
    step();
    InValid = 1'b0;
    check("r6.issue_diff", 32'(ExpDiff), 32'h01);
    step();
    check("r6.ws_state", 32'(DbgState), 32'd2);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("r6.ready", 32'(InReady), 32'd1);
    check("r6.busy",  32'(Busy), 32'd0);
    check("r6.set",   32'(ExpSet), 32'd0);
    check("r6.diff",  32'(ExpDiff), 32'd0);
    check("r6.go",    32'(Go), 32'd0);
    SumValid = 1'b1;
    Sum = 25'h1FFFFFF;
    step();
    SumValid = 1'b0;
    Sum = '0;
    step();
    check("r6.late_state", 32'(DbgState), 32'd0);
    check("r6.late_ffov",  32'(FFOValid), 32'd0);
    check("r6.late_idx",   32'(FFOIndex), 32'd0);

    // InValid held through an op, then Done coincides with InValid
    InValid = 1'b1;
    OpA = mk_op(8'h10, 23'h0);
    OpB = mk_op(8'h30, 23'h0);
    step();
    check("t7.go1",   32'(Go), 32'd1);
    check("t7.diff1", 32'(ExpDiff), 32'h20);
    check("t7.set1",  32'(ExpSet), 32'd0);
    OpA = mk_op(8'h40, 23'h0);
    OpB = mk_op(8'h08, 23'h0);
    step();
    check("t7.ws_ready", 32'(InReady), 32'd0);
    check("t7.ws_diff",  32'(ExpDiff), 32'h20);
    SumValid = 1'b1;
    Sum = 25'h0000100;
    step();
    SumValid = 1'b0;
    check("t7.find_diff", 32'(ExpDiff), 32'h20);
    step();
    check("t7.wd_idx",   32'(FFOIndex), 32'd8);
    check("t7.wd_diff",  32'(ExpDiff), 32'h20);
    check("t7.wd_ready", 32'(InReady), 32'd0);
    Done = 1'b1;
    step();
    Done = 1'b0;
    check("t7.idle_state", 32'(DbgState), 32'd0);
    check("t7.idle_go",    32'(Go), 32'd0);
    check("t7.idle_diff",  32'(ExpDiff), 32'd0);
    check("t7.idle_ready", 32'(InReady), 32'd1);
    step();
    InValid = 1'b0;
    check("t7.go2",   32'(Go), 32'd1);
    check("t7.diff2", 32'(ExpDiff), 32'h38);
    check("t7.set2",  32'(ExpSet), 32'd1);
    step();
    SumValid = 1'b1;
    Sum = 25'h0400000;
    step();
    SumValid = 1'b0;
    step();
    check("t7.idx2", 32'(FFOIndex), 32'd22);
    Done = 1'b1;
    step();
    Done = 1'b0;
    check("t7.end_busy", 32'(Busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
